// File: rtl/spd_pkg.sv
// Shared helpers for the register-exchange survivor-path decoder:
// log2 sizing, trellis predecessor and state-count derivation from K.
package spd_pkg;

  localparam int K_DEF = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  // State s is reached from (2s mod N) or (2s mod N)|1; d picks the odd one.
  function automatic int pred(input int s, input int d, input int k);
    return ((2 * s) % num_states(k)) | d;
  endfunction

endpackage

// File: rtl/spd_min_select.sv
// Binary argmin tree over N unsigned metrics; lowest index wins ties.
module spd_min_select
  import spd_pkg::*;
#(
  parameter int N    = 4,
  parameter int PM_W = 4,
  parameter int IW   = clog2(N)
) (
  input  logic [N*PM_W-1:0] pm,
  output logic [IW-1:0]     idx
);

  for (genvar l = 0; l <= IW; l++) begin : lv
    localparam int W = N >> l;
    logic [PM_W-1:0] v  [W];
    logic [IW-1:0]   ix [W];
    if (l == 0) begin : leaf
      for (genvar s = 0; s < W; s++) begin : g
        assign v[s]  = pm[s*PM_W +: PM_W];
        assign ix[s] = IW'(s);
      end
    end else begin : node
      for (genvar j = 0; j < W; j++) begin : g
        // Right child covers higher indices, so it only wins when strictly smaller.
        logic take_r;
        assign take_r = lv[l-1].v[2*j+1] < lv[l-1].v[2*j];
        assign v[j]   = take_r ? lv[l-1].v[2*j+1]  : lv[l-1].v[2*j];
        assign ix[j]  = take_r ? lv[l-1].ix[2*j+1] : lv[l-1].ix[2*j];
      end
    end
  end

  assign idx = lv[IW].ix[0];

endmodule

// File: rtl/spd_regex.sv
// Register-exchange survivor-path decoder with fill counter and flush.
// Define SPD_MAJORITY_EN to vote out_bit over all survivors instead of the best one.
module spd_regex
  import spd_pkg::*;
#(
  parameter  int K     = K_DEF,
  parameter  int DEPTH = 15,
  parameter  int PM_W  = 4,
  localparam int NS    = 1 << (K - 1),
  localparam int SW    = K - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NS-1:0]    dec,
  input  logic [NS*PM_W-1:0] pm,
  output logic             out_valid,
  output logic             out_bit,
  output logic [SW-1:0]    out_state
);

  localparam int CW = clog2(DEPTH + 1);

  logic [NS-1:0][DEPTH-1:0] rows, nrows;
  logic [CW-1:0]            cnt;
  logic [SW-1:0]            best;
  logic                     fin_bit;

  spd_min_select #(.N(NS), .PM_W(PM_W), .IW(SW)) u_min (
    .pm  (pm),
    .idx (best)
  );

  for (genvar s = 0; s < NS; s++) begin : g_row
    localparam int P0 = pred(s, 0, K);
    logic [SW-1:0] pi;
    assign pi       = SW'(P0) | SW'(dec[s]);
    assign nrows[s] = {rows[pi][DEPTH-2:0], 1'(s >> (K - 2))};
  end

`ifdef SPD_MAJORITY_EN
  logic [SW:0] ones;
  always_comb begin
    ones = '0;
    for (int s = 0; s < NS; s++) ones = ones + (SW+1)'(nrows[s][DEPTH-1]);
    fin_bit = ones > (SW+1)'(NS / 2);
  end
`else
  assign fin_bit = nrows[best][DEPTH-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_state <= '0;
    end else if (clear) begin
      rows      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_state <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        rows      <= nrows;
        if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
        // Valid once this step completes DEPTH steps of history.
        out_valid <= cnt >= CW'(DEPTH - 1);
        out_bit   <= fin_bit;
        out_state <= best;
      end
    end
  end

endmodule

// File: tb/tb_spd_regex.sv
// Self-checking bench for spd_regex: directed tables plus random steps
// checked against a traceback reference built from the stored decisions.
module tb_spd_regex;

  localparam int K = 3, DEPTH = 15, PM_W = 4, NS = 4;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid;
  logic [3:0]  dec;
  logic [15:0] pm;
  logic        out_valid, out_bit;
  logic [1:0]  out_state;

  spd_regex #(.K(K), .DEPTH(DEPTH), .PM_W(PM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .dec       (dec),
    .pm        (pm),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [3:0] dh [0:4095];
  int nstep = 0;
  int exp_state = 0;
  int last_bit = 0;

  typedef struct {
    logic [15:0] pm;
    int          st;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic int argmin(input logic [15:0] p);
    int b;
    b = 0;
    for (int s = 1; s < NS; s++)
      if (p[s*4 +: 4] < p[b*4 +: 4]) b = s;
    return b;
  endfunction

  // Walk back DEPTH-1 decisions from s; the msb of the reached state is the old input.
  function automatic int trace(input int s0);
    int st;
    logic [3:0] d;
    st = s0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      d  = dh[(nstep - j) & 4095];
      st = ((2 * st) % NS) | int'(d[st]);
    end
    return st >> (K - 2);
  endfunction

  function automatic int ref_bit(input int b);
`ifdef SPD_MAJORITY_EN
    int ones;
    ones = 0;
    for (int s = 0; s < NS; s++) ones += trace(s);
    return (ones > NS / 2) ? 1 : 0;
`else
    return trace(b);
`endif
  endfunction

  function automatic logic [15:0] rnd_pm(input int hi);
    logic [15:0] p;
    for (int s = 0; s < NS; s++) p[s*4 +: 4] = 4'($urandom_range(0, hi));
    return p;
  endfunction

  task automatic do_step(input logic v, input logic [3:0] d, input logic [15:0] p, input string tag);
    in_valid = v; dec = d; pm = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v) begin
      nstep++;
      dh[nstep & 4095] = d;
      exp_state = argmin(p);
    end
    chk({tag, " valid"}, int'(out_valid), (v && nstep >= DEPTH) ? 1 : 0);
    chk({tag, " state"}, int'(out_state), exp_state);
    if (v && nstep >= DEPTH) chk({tag, " bit"}, int'(out_bit), ref_bit(exp_state));
    last_bit = int'(out_bit);
  endtask

  task automatic clear_step(input logic v, input string tag);
    clear = 1'b1; in_valid = v; dec = 4'($urandom); pm = rnd_pm(15);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    nstep = 0; exp_state = 0;
    chk({tag, " valid"}, int'(out_valid), 0);
    chk({tag, " bit"}, int'(out_bit), 0);
    chk({tag, " state"}, int'(out_state), 0);
  endtask

  int pat [5] = '{1, 0, 1, 1, 0};
  int inp [1:40];
  int m [4], nm [4];
  logic [3:0] rd [30];
  logic [15:0] rp [30];
  int bb [30];

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; dec = '0; pm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", int'(out_valid), 0);
    chk("reset bit", int'(out_bit), 0);
    chk("reset state", int'(out_state), 0);
    reset = 1'b0;

    // Fill: dec all zero, pm0 minimum; first valid on the 15th step.
    for (int i = 0; i < DEPTH; i++) do_step(1'b1, 4'b0000, 16'h5550, "fill");
    chk("fill last valid", int'(out_valid), 1);
    chk("fill last bit", int'(out_bit), 0);

    // Argmin table, written as {pm3,pm2,pm1,pm0}.
    tbl[0] = '{16'h5555, 0};
    tbl[1] = '{16'h0555, 3};
    tbl[2] = '{16'hFFFF, 0};
    tbl[3] = '{16'h1002, 1};
    tbl[4] = '{16'h0FF0, 0};
    tbl[5] = '{16'h3298, 2};
    tbl[6] = '{16'hEFFF, 3};
    for (int i = 0; i < 7; i++) begin
      do_step(1'b1, 4'($urandom), tbl[i].pm, "argmin");
      chk("argmin table", int'(out_state), tbl[i].st);
    end

    // Noise-free (7,5) code through a golden ACS; output equals input delayed.
    clear_step(1'b0, "acs clr");
    m = '{0, 8, 8, 8};
    begin
      int es, r, c0, c1, mn;
      logic [3:0] d;
      logic [15:0] p;
      es = 0;
      for (int n = 1; n <= 40; n++) begin
        inp[n] = pat[(n - 1) % 5];
        r  = (inp[n] << 2) | es;
        c0 = ^(3'(r) & 3'b111);
        c1 = ^(3'(r) & 3'b101);
        es = r >> 1;
        for (int s = 0; s < NS; s++) begin
          int bm [2];
          for (int k = 0; k < 2; k++) begin
            int pr, rr;
            pr = ((2 * s) % NS) | k;
            rr = ((s >> 1) << 2) | pr;
            bm[k] = m[pr] + ((^(3'(rr) & 3'b111)) != c0) + ((^(3'(rr) & 3'b101)) != c1);
          end
          d[s]  = bm[1] < bm[0];
          nm[s] = d[s] ? bm[1] : bm[0];
        end
        mn = nm[0];
        for (int s = 1; s < NS; s++) if (nm[s] < mn) mn = nm[s];
        for (int s = 0; s < NS; s++) begin
          m[s] = (nm[s] - mn > 15) ? 15 : nm[s] - mn;
          p[s*4 +: 4] = 4'(m[s]);
        end
        do_step(1'b1, d, p, "acs");
`ifndef SPD_MAJORITY_EN
        if (nstep >= DEPTH) chk("acs delayed input", last_bit, inp[nstep - DEPTH + 1]);
`endif
      end
    end

    // Same random steps back-to-back and with 1-of-3 duty.
    clear_step(1'b0, "bb clr");
    for (int i = 0; i < 30; i++) begin
      rd[i] = 4'($urandom); rp[i] = rnd_pm(15);
      do_step(1'b1, rd[i], rp[i], "b2b");
      bb[i] = last_bit;
    end
    clear_step(1'b0, "gap clr");
    for (int i = 0; i < 30; i++) begin
      do_step(1'b1, rd[i], rp[i], "gap");
      if (i >= DEPTH - 1) chk("gap vs b2b", last_bit, bb[i]);
      do_step(1'b0, 4'($urandom), rnd_pm(15), "gap idle");
      do_step(1'b0, 4'($urandom), rnd_pm(15), "gap idle");
    end

    // clear wins over a simultaneous step; refill needs DEPTH fresh steps.
    for (int i = 0; i < 20; i++) do_step(1'b1, 4'($urandom), rnd_pm(15), "pre clr");
    clear_step(1'b1, "clr+step");
    for (int i = 0; i < DEPTH; i++) do_step(1'b1, 4'($urandom), rnd_pm(15), "post clr");
    chk("post clr valid", int'(out_valid), 1);

    // Asynchronous reset between edges.
    do_step(1'b1, 4'($urandom), 16'h0555, "pre rst");
    #2 reset = 1'b1;
    #1;
    chk("async rst valid", int'(out_valid), 0);
    chk("async rst bit", int'(out_bit), 0);
    chk("async rst state", int'(out_state), 0);
    #2 reset = 1'b0;
    nstep = 0; exp_state = 0;
    for (int i = 0; i < DEPTH + 1; i++) do_step(1'b1, 4'($urandom), rnd_pm(15), "post rst");

    // Random mixed traffic with frequent metric ties.
    for (int i = 0; i < 300; i++)
      do_step(($urandom % 3) != 0, 4'($urandom), rnd_pm(3), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
